// File: rtl/fft_iter_approx.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load, one butterfly per cycle, natural-order unload.
// Butterfly outputs can be halved per stage (SCALE) and have TRUNC LSBs forced to zero.
module fft_iter_approx #(
  parameter int LOG2N   = 3,
  parameter int DW      = 16,
  parameter int TW_FRAC = 8,
  parameter int TRUNC   = 0,
  parameter int SCALE   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [LOG2N-1:0]     out_idx,
  output logic                 out_last,
  output logic                 busy
);

  localparam int N   = 1 << LOG2N;
  localparam int NH  = N / 2;
  localparam int TWW = TW_FRAC + 2;
  localparam int PW  = DW + TW_FRAC + 2;
  localparam real PI = 3.141592653589793;
  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_COMP   = 2'd1;
  localparam logic [1:0] S_UNLOAD = 2'd2;
  localparam logic [LOG2N-2:0] J_LAST   = (LOG2N-1)'(NH - 1);
  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);
  localparam logic [2:0]       S_FINAL  = 3'(LOG2N - 1);
  localparam logic [DW-1:0]    TMASK    = {DW{1'b1}} << TRUNC;

  logic [1:0]            r_state;
  logic [LOG2N-1:0]      r_cnt;
  logic [2:0]            r_stage;
  logic [LOG2N-2:0]      r_j;
  logic [LOG2N-1:0]      r_idx;
  logic                  r_out_valid;
  logic signed [DW-1:0]  r_out_re;
  logic signed [DW-1:0]  r_out_im;
  logic [2*DW-1:0]       r_mem [N];

  logic signed [TWW-1:0] w_tw_re [NH];
  logic signed [TWW-1:0] w_tw_im [NH];

  // Twiddle ROM: w = exp(-j*2*pi*k/N), rounded half away from zero.
  for (genvar gi = 0; gi < NH; gi++) begin : g_tw
    localparam real ANG = 2.0 * PI * real'(gi) / real'(N);
    localparam real XR  = real'(1 << TW_FRAC) * $cos(ANG);
    localparam real XI  = real'(1 << TW_FRAC) * $sin(ANG);
    localparam int  WR  = (XR >= 0.0) ? $rtoi(XR + 0.5) : -$rtoi(0.5 - XR);
    localparam int  WI  = (XI >= 0.0) ? -$rtoi(XI + 0.5) : $rtoi(0.5 - XI);
    assign w_tw_re[gi] = TWW'(WR);
    assign w_tw_im[gi] = TWW'(WI);
  end

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic signed [DW-1:0] post(input logic signed [DW:0] v);
    logic signed [DW:0] s;
    s = (SCALE != 0) ? (v >>> 1) : v;
    return DW'(s) & TMASK;
  endfunction

  logic                  w_load_fire;
  logic [LOG2N-1:0]      w_j_ext, w_hmask, w_low, w_a, w_b;
  logic [LOG2N-2:0]      w_k;
  logic signed [DW-1:0]  w_ar, w_ai, w_br, w_bi;
  logic signed [TWW-1:0] w_wr, w_wi;
  logic signed [PW-1:0]  w_pr, w_pi;
  logic signed [DW:0]    w_tr, w_ti;
  logic signed [DW-1:0]  w_na_re, w_na_im, w_nb_re, w_nb_im;

  assign w_load_fire = in_valid && (r_state == S_LOAD);

  always_comb begin
    w_j_ext = {1'b0, r_j};
    w_hmask = ~({LOG2N{1'b1}} << r_stage);
    w_low   = w_j_ext & w_hmask;
    w_a     = ((w_j_ext & ~w_hmask) << 1) | w_low;
    w_b     = w_a + (LOG2N'(1) << r_stage);
    w_k     = (LOG2N-1)'(w_low << (S_FINAL - r_stage));
    {w_ar, w_ai} = r_mem[w_a];
    {w_br, w_bi} = r_mem[w_b];
    w_wr    = w_tw_re[w_k];
    w_wi    = w_tw_im[w_k];
    w_pr    = PW'(w_wr) * PW'(w_br) - PW'(w_wi) * PW'(w_bi);
    w_pi    = PW'(w_wr) * PW'(w_bi) + PW'(w_wi) * PW'(w_br);
    w_tr    = (DW+1)'(w_pr >>> TW_FRAC);
    w_ti    = (DW+1)'(w_pi >>> TW_FRAC);
    w_na_re = post((DW+1)'(w_ar) + w_tr);
    w_na_im = post((DW+1)'(w_ai) + w_ti);
    w_nb_re = post((DW+1)'(w_ar) - w_tr);
    w_nb_im = post((DW+1)'(w_ai) - w_ti);
  end

  // Sample storage has no reset; its contents are meaningless until a frame is loaded.
  always_ff @(posedge clk) begin
    if (w_load_fire) r_mem[bitrev(r_cnt)] <= {in_re, in_im};
    if (r_state == S_COMP) begin
      r_mem[w_a] <= {w_na_re, w_na_im};
      r_mem[w_b] <= {w_nb_re, w_nb_im};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_j         <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == IDX_LAST) begin
              r_state <= S_COMP;
              r_stage <= '0;
              r_j     <= '0;
            end
          end
        end
        S_COMP: begin
          if (r_j == J_LAST) begin
            r_j <= '0;
            if (r_stage == S_FINAL) r_state <= S_UNLOAD;
            else                    r_stage <= r_stage + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_UNLOAD: begin
          // First UNLOAD cycle only primes the output registers with bin 0.
          if (!r_out_valid) begin
            r_out_valid          <= 1'b1;
            {r_out_re, r_out_im} <= r_mem[r_idx];
          end else if (out_ready) begin
            if (r_idx == IDX_LAST) begin
              r_out_valid <= 1'b0;
              r_idx       <= '0;
              r_state     <= S_LOAD;
            end else begin
              r_idx                <= r_idx + 1'b1;
              {r_out_re, r_out_im} <= r_mem[r_idx + 1'b1];
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign busy      = (r_state != S_LOAD);
  assign out_valid = r_out_valid;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_idx   = r_idx;
  assign out_last  = r_out_valid && (r_idx == IDX_LAST);

endmodule

// File: tb/tb_fft_iter_approx.sv
// Directed bench for fft_iter_approx: three N=8 instances (exact, SCALE=1, TRUNC=2) share one stimulus.
module tb_fft_iter_approx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;

  logic in_rdy [3];
  logic o_valid [3];
  logic o_last [3];
  logic o_busy [3];
  logic signed [15:0] o_re [3];
  logic signed [15:0] o_im [3];
  logic [2:0] o_idx [3];

  int checks = 0;
  int fails = 0;
  int fr_re [8];
  int exp_re [3][8];
  int exp_im [3][8];

  always #5 clk = ~clk;

  fft_iter_approx #(.LOG2N(3), .DW(16), .TW_FRAC(8), .TRUNC(0), .SCALE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_re(in_re), .in_im(in_im),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_re(o_re[0]), .out_im(o_im[0]),
    .out_idx(o_idx[0]), .out_last(o_last[0]), .busy(o_busy[0]));

  fft_iter_approx #(.LOG2N(3), .DW(16), .TW_FRAC(8), .TRUNC(0), .SCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_re(in_re), .in_im(in_im),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_re(o_re[1]), .out_im(o_im[1]),
    .out_idx(o_idx[1]), .out_last(o_last[1]), .busy(o_busy[1]));

  fft_iter_approx #(.LOG2N(3), .DW(16), .TW_FRAC(8), .TRUNC(2), .SCALE(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]), .in_re(in_re), .in_im(in_im),
    .out_valid(o_valid[2]), .out_ready(out_ready), .out_re(o_re[2]), .out_im(o_im[2]),
    .out_idx(o_idx[2]), .out_last(o_last[2]), .busy(o_busy[2]));

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 8; i++) begin
      int w;
      in_valid = 1'b1;
      in_re = 16'(fr_re[i]);
      in_im = '0;
      w = 0;
      while (!in_rdy[0] && w < 50) begin
        step();
        w++;
      end
      if (w >= 50) chk("in_ready_timeout", 0, 1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_first(input int exp_lat, input bit toggle);
    int lat;
    lat = 0;
    while (!o_valid[0] && lat < 40) begin
      if (toggle) begin
        in_valid = lat[0];
        in_re = 16'($urandom);
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("first_valid", o_valid[0], 1);
    if (exp_lat > 0) chk("latency", lat, exp_lat);
  endtask

  task automatic recv(input string name, input int stall_at);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("%s d%0d b%0d valid", name, d, i), o_valid[d], 1);
        chk($sformatf("%s d%0d b%0d idx", name, d, i), o_idx[d], i);
        chk($sformatf("%s d%0d b%0d re", name, d, i), o_re[d], exp_re[d][i]);
        chk($sformatf("%s d%0d b%0d im", name, d, i), o_im[d], exp_im[d][i]);
        chk($sformatf("%s d%0d b%0d last", name, d, i), o_last[d], (i == 7) ? 1 : 0);
      end
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          step();
          for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s d%0d stall%0d valid", name, d, c), o_valid[d], 1);
            chk($sformatf("%s d%0d stall%0d idx", name, d, c), o_idx[d], i);
            chk($sformatf("%s d%0d stall%0d re", name, d, c), o_re[d], exp_re[d][i]);
            chk($sformatf("%s d%0d stall%0d im", name, d, c), o_im[d], exp_im[d][i]);
          end
        end
        out_ready = 1'b1;
      end
      step();
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d done valid", name, d), o_valid[d], 0);
      chk($sformatf("%s d%0d done in_ready", name, d), in_rdy[d], 1);
    end
    out_ready = 1'b0;
    $display("frame %s: 8 bins received, checks=%0d", name, checks);
  endtask

  initial begin
    // Reset state
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst d%0d valid", d), o_valid[d], 0);
      chk($sformatf("rst d%0d busy", d), o_busy[d], 0);
      chk($sformatf("rst d%0d idx", d), o_idx[d], 0);
      chk($sformatf("rst d%0d last", d), o_last[d], 0);
      chk($sformatf("rst d%0d re", d), o_re[d], 0);
      chk($sformatf("rst d%0d im", d), o_im[d], 0);
    end
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 3; d++) chk($sformatf("rst d%0d in_ready", d), in_rdy[d], 1);

    // Impulse: flat spectrum, exact 13-cycle latency
    fr_re = '{1000, 0, 0, 0, 0, 0, 0, 0};
    send_frame();
    wait_first(13, 1'b0);
    exp_re = '{'{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000},
               '{125, 125, 125, 125, 125, 125, 125, 125},
               '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000}};
    exp_im = '{'{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};
    recv("impulse", -1);

    // DC, with in_valid toggling during COMP
    fr_re = '{100, 100, 100, 100, 100, 100, 100, 100};
    send_frame();
    wait_first(13, 1'b1);
    exp_re = '{'{800, 0, 0, 0, 0, 0, 0, 0}, '{100, 0, 0, 0, 0, 0, 0, 0}, '{800, 0, 0, 0, 0, 0, 0, 0}};
    recv("dc", -1);

    // Alternating sign lands in bin 4
    fr_re = '{100, -100, 100, -100, 100, -100, 100, -100};
    send_frame();
    wait_first(13, 1'b0);
    exp_re = '{'{0, 0, 0, 0, 800, 0, 0, 0}, '{0, 0, 0, 0, 100, 0, 0, 0}, '{0, 0, 0, 0, 800, 0, 0, 0}};
    recv("alt", -1);

    // Overflow wraps without scaling; SCALE=1 keeps it in range
    fr_re = '{8000, 8000, 8000, 8000, 8000, 8000, 8000, 8000};
    send_frame();
    wait_first(13, 1'b0);
    exp_re = '{'{-1536, 0, 0, 0, 0, 0, 0, 0}, '{8000, 0, 0, 0, 0, 0, 0, 0}, '{-1536, 0, 0, 0, 0, 0, 0, 0}};
    recv("overflow", -1);

    // Delayed impulse exercises every twiddle and floor rounding; stall at bin 3
    fr_re = '{0, 1000, 0, 0, 0, 0, 0, 0};
    send_frame();
    wait_first(13, 1'b0);
    exp_re = '{'{1000, 707, 0, -708, -1000, -707, 0, 708},
               '{125, 88, 0, -89, -125, -88, 0, 88},
               '{1000, 704, 0, -708, -1000, -708, 0, 708}};
    exp_im = '{'{0, -708, -1000, -708, 0, 708, 1000, 708},
               '{0, -89, -125, -89, 0, 88, 125, 88},
               '{0, -708, -1000, -708, 0, 708, 1000, 708}};
    recv("twiddle", 3);

    // Truncation: 1001 reads back as 1000 on the TRUNC=2 instance
    fr_re = '{1001, 0, 0, 0, 0, 0, 0, 0};
    send_frame();
    wait_first(13, 1'b0);
    exp_re = '{'{1001, 1001, 1001, 1001, 1001, 1001, 1001, 1001},
               '{125, 125, 125, 125, 125, 125, 125, 125},
               '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000}};
    exp_im = '{'{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}};
    recv("trunc", -1);

    // Reset during the 6th COMP cycle, then a clean frame
    fr_re = '{0, 0, 0, 5000, 0, 0, 0, 0};
    send_frame();
    for (int c = 0; c < 5; c++) step();
    for (int d = 0; d < 3; d++) chk($sformatf("midcomp d%0d busy", d), o_busy[d], 1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst d%0d valid", d), o_valid[d], 0);
      chk($sformatf("midrst d%0d busy", d), o_busy[d], 0);
    end
    step();
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 3; d++) chk($sformatf("midrst d%0d in_ready", d), in_rdy[d], 1);
    fr_re = '{1000, 0, 0, 0, 0, 0, 0, 0};
    send_frame();
    wait_first(13, 1'b0);
    exp_re = '{'{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000},
               '{125, 125, 125, 125, 125, 125, 125, 125},
               '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000}};
    recv("post_reset", -1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
